// File: rtl/FetchUnitTypes.sv
// rtl/FetchUnitTypes.sv - fetch unit shared types for the return address stack
package FetchUnitTypes;

    localparam int PC_WIDTH        = 32;
    localparam int INSN_BYTE_WIDTH = 4;
    localparam int RAS_ENTRY_NUM   = 16;
    localparam int RAS_INDEX_WIDTH = $clog2(RAS_ENTRY_NUM);
    localparam int RAS_COUNT_WIDTH = RAS_INDEX_WIDTH + 1;

    typedef logic [PC_WIDTH-1:0]        PC_Path;
    typedef logic [RAS_INDEX_WIDTH-1:0] RAS_IndexPath;
    typedef logic [RAS_COUNT_WIDTH-1:0] RAS_CountPath;

    // Snapshot fetch attaches to every predicted branch so a mispredict can rewind the stack
    typedef struct packed {
        RAS_IndexPath tosPtr;
        RAS_CountPath count;
        PC_Path       topAddr;
    } RAS_CheckpointPath;

endpackage

// File: rtl/return_address_stack.sv
// rtl/return_address_stack.sv - circular return address stack with checkpoint recovery
module return_address_stack
    import FetchUnitTypes::*;
#(
    // Must match the depth the FetchUnitTypes index/count types are sized for
    parameter int RAS_ENTRY_NUM = FetchUnitTypes::RAS_ENTRY_NUM
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              pushValid,
    input  PC_Path            pushAddr,
    input  logic              popValid,
    output PC_Path            topAddr,
    output logic              topValid,
    output RAS_CheckpointPath ckptOut,
    input  logic              recoverValid,
    input  RAS_CheckpointPath recoverCkpt
);

    localparam RAS_CountPath FULL_COUNT = RAS_CountPath'(RAS_ENTRY_NUM);

    PC_Path       entry [RAS_ENTRY_NUM];
    RAS_IndexPath tosPtr;
    RAS_CountPath count;

    RAS_IndexPath nextTos;
    RAS_CountPath nextCount;
    logic         wrEn;
    RAS_IndexPath wrIdx;
    PC_Path       wrData;

    // Next pointer/count and the single entry write; recovery overrides any push/pop
    always_comb begin
        nextTos   = tosPtr;
        nextCount = count;
        wrEn      = 1'b0;
        wrIdx     = tosPtr;
        wrData    = pushAddr;
        if (recoverValid) begin
            nextTos   = recoverCkpt.tosPtr;
            nextCount = recoverCkpt.count;
            wrEn      = 1'b1;
            wrIdx     = recoverCkpt.tosPtr;
            wrData    = recoverCkpt.topAddr;
        end else if (pushValid && popValid && (count != '0)) begin
            // return immediately followed by a call: replace the top in place
            wrEn = 1'b1;
        end else if (pushValid) begin
            // wrap-around silently overwrites the oldest entry once full
            nextTos   = tosPtr + 1'b1;
            nextCount = (count == FULL_COUNT) ? count : count + 1'b1;
            wrEn      = 1'b1;
            wrIdx     = tosPtr + 1'b1;
        end else if (popValid && (count != '0)) begin
            nextTos   = tosPtr - 1'b1;
            nextCount = count - 1'b1;
        end
    end

    // Stack pointer, occupancy and flip-flop entry file
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            tosPtr <= '0;
            count  <= '0;
            for (int i = 0; i < RAS_ENTRY_NUM; i++) begin
                entry[i] <= '0;
            end
        end else begin
            tosPtr <= nextTos;
            count  <= nextCount;
            if (wrEn) begin
                entry[wrIdx] <= wrData;
            end
        end
    end

    // Outputs reflect current state only, never this cycle's requests
    always_comb begin
        topAddr         = entry[tosPtr];
        topValid        = (count != '0);
        ckptOut.tosPtr  = tosPtr;
        ckptOut.count   = count;
        ckptOut.topAddr = entry[tosPtr];
    end

endmodule

// File: tb/tb_return_address_stack.sv
// tb/tb_return_address_stack.sv - randomized self-checking bench for return_address_stack
module tb_return_address_stack;
    import FetchUnitTypes::*;

    localparam int D = 16;

    logic              clk;
    logic              rstN;
    logic              pushValid;
    PC_Path            pushAddr;
    logic              popValid;
    PC_Path            topAddr;
    logic              topValid;
    RAS_CheckpointPath ckptOut;
    logic              recoverValid;
    RAS_CheckpointPath recoverCkpt;

    int testCount;
    int failCount;

    // Reference: a circular buffer of D slots, a top index and an occupancy count
    logic [31:0] mEnt [D];
    int          mTos;
    int          mCnt;

    return_address_stack #(.RAS_ENTRY_NUM(D)) dut (
        .clk          (clk),
        .rstN         (rstN),
        .pushValid    (pushValid),
        .pushAddr     (pushAddr),
        .popValid     (popValid),
        .topAddr      (topAddr),
        .topValid     (topValid),
        .ckptOut      (ckptOut),
        .recoverValid (recoverValid),
        .recoverCkpt  (recoverCkpt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic RAS_CheckpointPath expCkpt();
        RAS_CheckpointPath e;
        e.tosPtr  = RAS_IndexPath'(mTos);
        e.count   = RAS_CountPath'(mCnt);
        e.topAddr = mEnt[mTos];
        return e;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < D; i++) mEnt[i] = '0;
        mTos = 0;
        mCnt = 0;
    endfunction

    function automatic void modelApply(input logic push, input logic [31:0] addr,
                                       input logic pop, input logic rec,
                                       input RAS_CheckpointPath ck);
        if (rec) begin
            mTos       = int'(ck.tosPtr);
            mCnt       = int'(ck.count);
            mEnt[mTos] = ck.topAddr;
        end else if (push && pop && mCnt > 0) begin
            mEnt[mTos] = addr;
        end else if (push) begin
            mTos       = (mTos + 1) % D;
            mEnt[mTos] = addr;
            if (mCnt < D) mCnt++;
        end else if (pop && mCnt > 0) begin
            mTos = (mTos + D - 1) % D;
            mCnt--;
        end
    endfunction

    task automatic checkAll(input string tag);
        checkValue({tag, "_top"}, 64'(topAddr), 64'(mEnt[mTos]));
        checkValue({tag, "_valid"}, 64'(topValid), 64'(mCnt != 0));
        checkValue({tag, "_ckpt"}, 64'(ckptOut), 64'(expCkpt()));
    endtask

    // One clock cycle of requests; ckptOut is checked against pre-update state before the edge
    task automatic step(input logic push, input logic [31:0] addr, input logic pop,
                        input logic rec, input RAS_CheckpointPath ck, input string tag);
        @(negedge clk);
        pushValid    = push;
        pushAddr     = addr;
        popValid     = pop;
        recoverValid = rec;
        recoverCkpt  = ck;
        #1;
        checkValue({tag, "_pre"}, 64'(ckptOut), 64'(expCkpt()));
        @(posedge clk);
        modelApply(push, addr, pop, rec, ck);
        #1;
        pushValid    = 1'b0;
        popValid     = 1'b0;
        recoverValid = 1'b0;
        checkAll(tag);
    endtask

    task automatic doReset(input string tag);
        #2;
        rstN = 1'b0;
        modelReset();
        #1;
        checkValue({tag, "_cnt_async"}, 64'(ckptOut.count), 64'd0);
        checkValue({tag, "_valid_async"}, 64'(topValid), 64'd0);
        checkValue({tag, "_ckpt_async"}, 64'(ckptOut), 64'd0);
        // requests during reset must be ignored
        pushValid = 1'b1;
        pushAddr  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        pushValid = 1'b0;
        checkValue({tag, "_held"}, 64'(ckptOut), 64'd0);
        @(negedge clk);
        rstN = 1'b1;
    endtask

    RAS_CheckpointPath noCk;
    RAS_CheckpointPath saved;
    RAS_CheckpointPath rc;
    logic rPush, rPop, rRec;

    initial begin
        testCount    = 0;
        failCount    = 0;
        rstN         = 1'b0;
        pushValid    = 1'b0;
        pushAddr     = '0;
        popValid     = 1'b0;
        recoverValid = 1'b0;
        noCk         = '0;
        recoverCkpt  = '0;
        modelReset();
        #1;
        doReset("rst0");

        // basic push/push/pop
        step(1, 32'h1004, 0, 0, noCk, "push1");
        step(1, 32'h2008, 0, 0, noCk, "push2");
        checkValue("basic_top", 64'(topAddr), 64'h2008);
        checkValue("basic_cnt", 64'(ckptOut.count), 64'd2);
        step(0, 32'h0, 1, 0, noCk, "pop1");
        checkValue("basic_pop_top", 64'(topAddr), 64'h1004);
        checkValue("basic_pop_valid", 64'(topValid), 64'd1);

        // overflow by one then drain completely
        doReset("rst1");
        for (int k = 0; k <= 16; k++) step(1, 32'h100 + 32'(4 * k), 0, 0, noCk, "ovf_push");
        checkValue("ovf_cnt", 64'(ckptOut.count), 64'd16);
        checkValue("ovf_top", 64'(topAddr), 64'h140);
        for (int i = 0; i < 16; i++) begin
            checkValue("drain_top", 64'(topAddr), 64'(32'h140 - 32'(4 * i)));
            step(0, 32'h0, 1, 0, noCk, "drain_pop");
        end
        checkValue("drain_empty", 64'(topValid), 64'd0);

        // pop on empty stack holds state
        doReset("rst2");
        step(0, 32'h0, 1, 0, noCk, "empty_pop");
        checkValue("empty_tos", 64'(ckptOut.tosPtr), 64'd0);
        checkValue("empty_cnt", 64'(ckptOut.count), 64'd0);
        checkValue("empty_top_known", 64'($isunknown(topAddr)), 64'd0);
        step(1, 32'h5550, 1, 0, noCk, "empty_pushpop");
        checkValue("empty_pp_cnt", 64'(ckptOut.count), 64'd1);

        // simultaneous push and pop replaces top
        doReset("rst3");
        step(1, 32'h1000, 0, 0, noCk, "pp_a");
        step(1, 32'h2000, 0, 0, noCk, "pp_b");
        step(1, 32'h3000, 0, 0, noCk, "pp_c");
        step(1, 32'h4000, 1, 0, noCk, "pp_both");
        checkValue("pp_top", 64'(topAddr), 64'h4000);
        checkValue("pp_cnt", 64'(ckptOut.count), 64'd3);

        // checkpoint and recovery, push in recover cycle dropped
        doReset("rst4");
        step(1, 32'h1004, 0, 0, noCk, "ck_a");
        step(1, 32'h2008, 0, 0, noCk, "ck_b");
        saved = ckptOut;
        checkValue("ck_saved", 64'(saved), {23'd0, 4'd2, 5'd2, 32'h2008});
        step(0, 32'h0, 1, 0, noCk, "ck_pop");
        step(1, 32'h9000, 0, 0, noCk, "ck_push");
        step(1, 32'h7777, 0, 1, saved, "ck_rec");
        checkValue("rec_top", 64'(topAddr), 64'h2008);
        checkValue("rec_cnt", 64'(ckptOut.count), 64'd2);
        checkValue("rec_tos", 64'(ckptOut.tosPtr), 64'd2);

        // asynchronous reset mid-sequence at count=5
        for (int k = 0; k < 3; k++) step(1, 32'hA000 + 32'(k * 4), 0, 0, noCk, "mid_push");
        checkValue("mid_cnt", 64'(ckptOut.count), 64'd5);
        doReset("rst5");

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            rPush = 1'($urandom_range(0, 1));
            rPop  = 1'($urandom_range(0, 2) == 0);
            rRec  = 1'($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 1) == 0) begin
                rc = ckptOut;
            end else begin
                rc.tosPtr  = RAS_IndexPath'($urandom_range(0, D - 1));
                rc.count   = RAS_CountPath'($urandom_range(0, D));
                rc.topAddr = $urandom;
            end
            step(rPush, $urandom, rPop, rRec, rc, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/return_address_stack.md
RETURN_ADDRESS_STACK -- requirements
Module: return_address_stack

Interface
REQ-001 SHALL have parameter RAS_ENTRY_NUM, default 16, meaning the stack depth in entries (power of two, >=4).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rstN  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port pushValid  input  1  fetch sees a BTB hit flagged RAS-push (call).
REQ-005 SHALL have port pushAddr  input  PC_Path  return address to push (call PC + INSN_BYTE_WIDTH).
REQ-006 SHALL have port popValid  input  1  fetch sees a BTB hit flagged RAS-pop (return).
REQ-007 SHALL have port topAddr  output  PC_Path  entry at top-of-stack, combinational from current state.
REQ-008 SHALL have port topValid  output  1  count != 0.
REQ-009 SHALL have port ckptOut  output  RAS_CheckpointPath  current {tosPtr, count, topAddr}, for fetch to attach to each predicted branch.
REQ-010 SHALL have port recoverValid  input  1  branch misprediction recovery request from the IntEx/commit side.
REQ-011 SHALL have port recoverCkpt  input  RAS_CheckpointPath  checkpoint to restore.

Function
REQ-012 SHALL keep tosPtr (log2(RAS_ENTRY_NUM) bits) pointing at the top entry and count (log2(RAS_ENTRY_NUM)+1 bits) of valid entries.
REQ-013 SHALL on push only: tosPtr <= tosPtr+1 (modulo depth), entry[tosPtr+1] <= pushAddr, count <= min(count+1, RAS_ENTRY_NUM).
REQ-014 SHALL on overflow (push at count=RAS_ENTRY_NUM) overwrite the oldest entry via wrap-around; count stays saturated.
REQ-015 SHALL on pop only with count>0: tosPtr <= tosPtr-1 (modulo), count <= count-1; entry contents unchanged.
REQ-016 SHALL on pop only with count=0: hold all state; topValid stays 0.
REQ-017 SHALL on simultaneous push and pop with count>0: entry[tosPtr] <= pushAddr, tosPtr and count unchanged.
REQ-018 SHALL on simultaneous push and pop with count=0: behave as push only.
REQ-019 SHALL on recoverValid: tosPtr <= recoverCkpt.tosPtr, count <= recoverCkpt.count, entry[recoverCkpt.tosPtr] <= recoverCkpt.topAddr; push/pop in that cycle ignored.
REQ-020 SHALL have 1-cycle latency: effects of push/pop/recover visible on topAddr, topValid and ckptOut in the next cycle, never the same cycle.
REQ-021 SHALL drive ckptOut from pre-update state of the current cycle.
REQ-022 SHALL present topAddr = entry[tosPtr] regardless of topValid.

Reset
REQ-023 SHALL on rstN low asynchronously set tosPtr=0, count=0, all entries=0; outputs topValid=0, topAddr=0, ckptOut=0.
REQ-024 SHALL ignore push, pop and recover while rstN is low; first update occurs on the first clk edge after deassertion.

Structure
REQ-025 SHALL place RAS_ENTRY_NUM, RAS_IndexPath, RAS_CountPath and struct RAS_CheckpointPath {tosPtr, count, topAddr} in FetchUnitTypes.
REQ-026 SHALL implement the entry array as a flip-flop register file inside the module, 1 write port, 1 read port; no sub-module.
REQ-027 SHALL have a single write path whose priority is recover > push.

Verification
REQ-028 SHALL cover: reset, push 0x1004, 0x2008 -> topAddr=0x2008, count=2; pop -> topAddr=0x1004, topValid=1.
REQ-029 SHALL cover: 17 pushes 0x100+4k (k=0..16), depth 16 -> count=16, topAddr=0x140; 16 pops -> topAddr sequence 0x140..0x104, then topValid=0.
REQ-030 SHALL cover: pop on empty -> tosPtr=0, count=0 held; no X on topAddr.
REQ-031 SHALL cover: count=3 top 0x3000, push 0x4000 + pop same cycle -> topAddr=0x4000, count=3.
REQ-032 SHALL cover: ckpt taken at {tosPtr=2,count=2,top=0x2008}, then pop and push 0x9000 -> recover -> topAddr=0x2008, count=2; push in recover cycle dropped.
REQ-033 SHALL cover: rstN asserted mid-sequence with count=5 -> count=0, topValid=0 immediately, without waiting for clk.
